inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl
//   Instruction fetch controller with a direct-mapped, one-word-per-line instruction
//   cache in front of a byte-wide RAM bus. A hit returns the cached word one cycle
//   after acceptance. A miss arbitrates for the bus, reads four bytes little-endian,
//   returns the word and fills the line.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset (wins over rdy and flush_i)
//   rdy          global enable; low freezes all state and outputs
//   if_req_i     fetch request, held until inst_done_o
//   pc_i         fetch address; bits [1:0] ignored
//   flush_i      abandon any fetch in progress
//   inst_done_o  one-cycle pulse, inst_o valid
//   inst_o       fetched instruction, holds between pulses
//   mem_req_o    RAM bus ownership request
//   mem_gnt_i    RAM bus grant
//   mem_a_o      RAM byte read address
//   mem_din_i    RAM read data, valid the cycle after its address under grant
module inst_fetch_ctrl #(
    parameter int unsigned ICACHE_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic        inst_done_o,
    output logic [31:0] inst_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_a_o,
    input  logic [7:0]  mem_din_i
);

    localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        FETCH,
        DONE
    } state_t;

    state_t                  state;
    logic [1:0]              byte_cnt;
    logic [31:0]             fetch_pc;   // word-aligned address of the fetch in flight
    logic [23:0]             asm_lo;     // low three bytes gathered so far
    logic [ICACHE_LINES-1:0] valid;

    logic [31:0]             data_mem [ICACHE_LINES];
    logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];

    logic [31:0]             req_pc;
    logic [IDX_W-1:0]        req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [IDX_W-1:0]        fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic                    accept;
    logic                    hit;
    logic                    fill_we;

    always_comb begin
        req_pc   = pc_i & 32'hFFFF_FFFC;
        req_idx  = req_pc[IDX_W+1:2];
        req_tag  = req_pc[31:IDX_W+2];
        fill_idx = fetch_pc[IDX_W+1:2];
        fill_tag = fetch_pc[31:IDX_W+2];
        // A request is only taken once the previous done pulse has cleared.
        accept   = (state == IDLE) && !inst_done_o && if_req_i;
        hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
        // Line is written on the edge that samples the last byte, unless flushed.
        fill_we  = !rst && rdy && !flush_i && (state == FETCH) && (byte_cnt == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[fill_idx] <= {mem_din_i, asm_lo};
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            byte_cnt    <= 2'd0;
            fetch_pc    <= 32'd0;
            asm_lo      <= 24'd0;
            valid       <= '0;
            inst_done_o <= 1'b0;
            inst_o      <= 32'd0;
            mem_req_o   <= 1'b0;
            mem_a_o     <= 32'd0;
        end else if (rdy) begin
            if (flush_i) begin
                state       <= IDLE;
                byte_cnt    <= 2'd0;
                mem_req_o   <= 1'b0;
                inst_done_o <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        inst_done_o <= 1'b0;
                        if (accept) begin
                            if (hit) begin
                                inst_done_o <= 1'b1;
                                inst_o      <= data_mem[req_idx];
                            end else begin
                                state     <= WAIT_GNT;
                                mem_req_o <= 1'b1;
                                mem_a_o   <= req_pc;
                                fetch_pc  <= req_pc;
                            end
                        end
                    end
                    WAIT_GNT: begin
                        // Address pc+0 goes out in the grant cycle itself.
                        if (mem_gnt_i) begin
                            state    <= FETCH;
                            byte_cnt <= 2'd0;
                            mem_a_o  <= fetch_pc + 32'd1;
                        end
                    end
                    FETCH: begin
                        unique case (byte_cnt)
                            2'd0: asm_lo[7:0]   <= mem_din_i;
                            2'd1: asm_lo[15:8]  <= mem_din_i;
                            2'd2: asm_lo[23:16] <= mem_din_i;
                            2'd3: begin
                                state       <= DONE;
                                inst_done_o <= 1'b1;
                                mem_req_o   <= 1'b0;
                                inst_o      <= {mem_din_i, asm_lo};
                                valid[fill_idx] <= 1'b1;
                            end
                        endcase
                        if (byte_cnt != 2'd3) begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end else begin
                            byte_cnt <= 2'd0;
                        end
                        // Addresses run one byte ahead of the data; pc+3 is held
                        // while its byte comes back.
                        if (byte_cnt < 2'd2) begin
                            mem_a_o <= fetch_pc + {30'd0, byte_cnt} + 32'd2;
                        end
                    end
                    DONE: begin
                        state       <= IDLE;
                        inst_done_o <= 1'b0;
                        byte_cnt    <= 2'd0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: byte RAM model, delayable grant model,
// scoreboard queue of expected instruction words.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        inst_done_o;
    logic [31:0] inst_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_din_i = 8'd0;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q [$];
    logic [7:0]  ram [256];
    int          gnt_delay = 0;
    int          gnt_wait = 0;
    logic [31:0] a_trace [32];
    bit          r_trace [32];

    inst_fetch_ctrl #(.ICACHE_LINES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .if_req_i    (if_req_i),
        .pc_i        (pc_i),
        .flush_i     (flush_i),
        .inst_done_o (inst_done_o),
        .inst_o      (inst_o),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_a_o     (mem_a_o),
        .mem_din_i   (mem_din_i)
    );

    always #5 clk = ~clk;

    // Arbiter: grant after gnt_delay cycles of request, held while requested.
    always @(posedge clk) begin
        if (!mem_req_o) gnt_wait <= 0;
        else            gnt_wait <= gnt_wait + 1;
    end
    assign mem_gnt_i = mem_req_o && (gnt_wait >= gnt_delay);

    // RAM: registered read, frozen together with the rest of the system by rdy.
    always @(posedge clk) begin
        if (rdy) mem_din_i <= ram[mem_a_o[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        for (int i = 0; i < 4 && inst_done_o; i++) tick();
    endtask

    // Drives one request and waits for inst_done_o; records mem_a_o/mem_req_o per cycle.
    // stall_at != 0 drops rdy for the edges ending cycles t+stall_at-1 and t+stall_at.
    task automatic fetch(input logic [31:0] pc, input bit do_settle, input int stall_at,
                         output int lat, output logic [31:0] word, output bit req_seen,
                         output bit a_held);
        if (do_settle) settle();
        lat = -1; word = 32'd0; req_seen = 1'b0; a_held = 1'b1;
        if_req_i = 1'b1;
        pc_i = pc;
        for (int c = 1; c < 32; c++) begin
            rdy = !(stall_at != 0 && (c == stall_at || c == stall_at + 1));
            tick();
            a_trace[c] = mem_a_o;
            r_trace[c] = mem_req_o;
            if (mem_req_o) req_seen = 1'b1;
            if (mem_req_o && !mem_gnt_i && mem_a_o !== {pc[31:2], 2'b00}) a_held = 1'b0;
            if (inst_done_o) begin
                lat = c;
                word = inst_o;
                break;
            end
        end
        rdy = 1'b1;
        if_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b0; if_req_i = 1'b1; pc_i = 32'h0; flush_i = 1'b0;
        tick(); tick();
        vectors++; if (inst_done_o !== 1'b0) begin miscompares++;
            $display("FAIL reset_done got %b want 0", inst_done_o); end
        vectors++; if (inst_o !== 32'd0) begin miscompares++;
            $display("FAIL reset_inst got %h want 0", inst_o); end
        vectors++; if (mem_req_o !== 1'b0) begin miscompares++;
            $display("FAIL reset_mem_req got %b want 0", mem_req_o); end
        vectors++; if (mem_a_o !== 32'd0) begin miscompares++;
            $display("FAIL reset_mem_a got %h want 0", mem_a_o); end
        rst = 1'b0; rdy = 1'b1; if_req_i = 1'b0;
        tick();
    endtask

    task automatic test_miss();
        int lat; logic [31:0] word, e; bit rs, ah;
        exp_q.push_back(32'h0000_0513);
        fetch(32'h0, 1'b1, 0, lat, word, rs, ah);
        e = exp_q.pop_front();
        vectors++; if (lat != 6) begin miscompares++;
            $display("FAIL miss_latency got %0d want 6", lat); end
        vectors++; if (word !== e) begin miscompares++;
            $display("FAIL miss_word got %h want %h", word, e); end
        vectors++; if (r_trace[1] !== 1'b1) begin miscompares++;
            $display("FAIL miss_req_t1 got %b want 1", r_trace[1]); end
        vectors++; if (a_trace[1] !== 32'h0 || a_trace[2] !== 32'h1 || a_trace[3] !== 32'h2 ||
                       a_trace[4] !== 32'h3) begin miscompares++;
            $display("FAIL miss_addr_seq got %h %h %h %h want 0 1 2 3",
                     a_trace[1], a_trace[2], a_trace[3], a_trace[4]); end
    endtask

    task automatic test_hit();
        int lat; logic [31:0] word, e; bit rs, ah;
        exp_q.push_back(32'h0000_0513);
        fetch(32'h0, 1'b1, 0, lat, word, rs, ah);
        e = exp_q.pop_front();
        vectors++; if (lat != 1) begin miscompares++;
            $display("FAIL hit_latency got %0d want 1", lat); end
        vectors++; if (word !== e) begin miscompares++;
            $display("FAIL hit_word got %h want %h", word, e); end
        vectors++; if (rs !== 1'b0) begin miscompares++;
            $display("FAIL hit_mem_req got %b want 0", rs); end
        tick(); tick();
        vectors++; if (inst_done_o !== 1'b0) begin miscompares++;
            $display("FAIL hit_pulse_width got %b want 0", inst_done_o); end
        vectors++; if (inst_o !== 32'h0000_0513) begin miscompares++;
            $display("FAIL hit_inst_hold got %h want 00000513", inst_o); end
    endtask

    task automatic test_conflict();
        int lat; logic [31:0] word, e; bit rs, ah;
        logic [31:0] pcs [3];
        int          lats [3];
        pcs[0] = 32'h40; pcs[1] = 32'h0; pcs[2] = 32'h0;
        lats[0] = 6;     lats[1] = 6;    lats[2] = 1;
        exp_q.push_back(32'h0010_0093);
        exp_q.push_back(32'h0000_0513);
        exp_q.push_back(32'h0000_0513);
        for (int i = 0; i < 3; i++) begin
            fetch(pcs[i], 1'b1, 0, lat, word, rs, ah);
            e = exp_q.pop_front();
            vectors++; if (lat != lats[i]) begin miscompares++;
                $display("FAIL conflict_latency[%0d] got %0d want %0d", i, lat, lats[i]); end
            vectors++; if (word !== e) begin miscompares++;
                $display("FAIL conflict_word[%0d] got %h want %h", i, word, e); end
        end
    endtask

    task automatic test_gnt_delay();
        int lat; logic [31:0] word, e; bit rs, ah;
        gnt_delay = 3;
        exp_q.push_back(32'h1234_12b7);
        fetch(32'h08, 1'b1, 0, lat, word, rs, ah);
        e = exp_q.pop_front();
        gnt_delay = 0;
        vectors++; if (lat != 9) begin miscompares++;
            $display("FAIL gnt_delay_latency got %0d want 9", lat); end
        vectors++; if (ah !== 1'b1) begin miscompares++;
            $display("FAIL gnt_delay_addr_hold got %b want 1", ah); end
        vectors++; if (word !== e) begin miscompares++;
            $display("FAIL gnt_delay_word got %h want %h", word, e); end
    endtask

    task automatic test_rdy_stall();
        int lat; logic [31:0] word, e; bit rs, ah;
        exp_q.push_back(32'h00a5_8533);
        fetch(32'h0C, 1'b1, 4, lat, word, rs, ah);
        e = exp_q.pop_front();
        vectors++; if (lat != 8) begin miscompares++;
            $display("FAIL stall_latency got %0d want 8", lat); end
        vectors++; if (word !== e) begin miscompares++;
            $display("FAIL stall_word got %h want %h", word, e); end
        vectors++; if (a_trace[3] !== 32'h0E || a_trace[4] !== 32'h0E || a_trace[5] !== 32'h0E ||
                       a_trace[6] !== 32'h0F) begin miscompares++;
            $display("FAIL stall_addr got %h %h %h %h want e e e f",
                     a_trace[3], a_trace[4], a_trace[5], a_trace[6]); end
    endtask

    task automatic test_flush();
        int lat; logic [31:0] word, e; bit rs, ah; bit saw_done;
        settle();
        if_req_i = 1'b1; pc_i = 32'h80;
        tick(); tick(); tick();
        flush_i = 1'b1; if_req_i = 1'b0;
        tick();
        flush_i = 1'b0;
        vectors++; if (mem_req_o !== 1'b0) begin miscompares++;
            $display("FAIL flush_mem_req got %b want 0", mem_req_o); end
        saw_done = inst_done_o;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (inst_done_o) saw_done = 1'b1;
        end
        vectors++; if (saw_done !== 1'b0) begin miscompares++;
            $display("FAIL flush_no_done got %b want 0", saw_done); end
        exp_q.push_back(32'hff01_0113);
        fetch(32'h80, 1'b1, 0, lat, word, rs, ah);
        e = exp_q.pop_front();
        vectors++; if (lat != 6) begin miscompares++;
            $display("FAIL flush_refetch_latency got %0d want 6", lat); end
        vectors++; if (word !== e) begin miscompares++;
            $display("FAIL flush_refetch_word got %h want %h", word, e); end
    endtask

    task automatic test_flush_final();
        int lat; logic [31:0] word, e; bit rs, ah;
        settle();
        if_req_i = 1'b1; pc_i = 32'h90;
        for (int i = 0; i < 5; i++) tick();
        flush_i = 1'b1; if_req_i = 1'b0;
        tick();
        flush_i = 1'b0;
        vectors++; if (inst_done_o !== 1'b0 || mem_req_o !== 1'b0) begin miscompares++;
            $display("FAIL flush_final_outputs got done=%b req=%b want 0 0",
                     inst_done_o, mem_req_o); end
        tick();
        exp_q.push_back(32'h0000_006f);
        fetch(32'h90, 1'b1, 0, lat, word, rs, ah);
        e = exp_q.pop_front();
        vectors++; if (lat != 6) begin miscompares++;
            $display("FAIL flush_final_no_fill got latency %0d want 6", lat); end
        vectors++; if (word !== e) begin miscompares++;
            $display("FAIL flush_final_word got %h want %h", word, e); end
    endtask

    task automatic test_flush_hit();
        int lat; logic [31:0] word, e; bit rs, ah;
        settle();
        if_req_i = 1'b1; pc_i = 32'h80; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; if_req_i = 1'b0;
        vectors++; if (inst_done_o !== 1'b0) begin miscompares++;
            $display("FAIL flush_hit_done got %b want 0", inst_done_o); end
        vectors++; if (inst_o !== 32'h0000_006f) begin miscompares++;
            $display("FAIL flush_hit_inst_hold got %h want 0000006f", inst_o); end
        tick();
        exp_q.push_back(32'hff01_0113);
        fetch(32'h80, 1'b1, 0, lat, word, rs, ah);
        e = exp_q.pop_front();
        vectors++; if (lat != 1 || word !== e) begin miscompares++;
            $display("FAIL flush_hit_rehit got lat=%0d word=%h want 1 %h", lat, word, e); end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] word, e; bit rs, ah;
        exp_q.push_back(32'h0000_8067);
        fetch(32'hFFFF_FFFC, 1'b1, 0, lat, word, rs, ah);
        e = exp_q.pop_front();
        vectors++; if (lat != 6 || word !== e) begin miscompares++;
            $display("FAIL wrap_fetch got lat=%0d word=%h want 6 %h", lat, word, e); end
        vectors++; if (a_trace[1] !== 32'hFFFF_FFFC || a_trace[4] !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL wrap_addr got %h %h want fffffffc ffffffff", a_trace[1], a_trace[4]); end
        exp_q.push_back(32'h0000_8067);
        fetch(32'hFFFF_FFFE, 1'b1, 0, lat, word, rs, ah);
        e = exp_q.pop_front();
        vectors++; if (lat != 1 || word !== e) begin miscompares++;
            $display("FAIL pc_low_bits got lat=%0d word=%h want 1 %h", lat, word, e); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] word, e; bit rs, ah;
        exp_q.push_back(32'h0000_8067);
        exp_q.push_back(32'h0000_8067);
        fetch(32'hFFFF_FFFC, 1'b1, 0, lat, word, rs, ah);
        e = exp_q.pop_front();
        vectors++; if (lat != 1 || word !== e) begin miscompares++;
            $display("FAIL b2b_first got lat=%0d word=%h want 1 %h", lat, word, e); end
        // Raised during the done pulse: must wait one cycle before acceptance.
        fetch(32'hFFFF_FFFC, 1'b0, 0, lat, word, rs, ah);
        e = exp_q.pop_front();
        vectors++; if (lat != 2 || word !== e) begin miscompares++;
            $display("FAIL b2b_second got lat=%0d word=%h want 2 %h", lat, word, e); end
    endtask

    task automatic test_reset_midfetch();
        int lat; logic [31:0] word, e; bit rs, ah;
        settle();
        if_req_i = 1'b1; pc_i = 32'h20;
        tick(); tick(); tick();
        if_req_i = 1'b0; rst = 1'b1; rdy = 1'b0; flush_i = 1'b0;
        tick();
        vectors++; if (mem_req_o !== 1'b0 || inst_done_o !== 1'b0 || inst_o !== 32'd0 ||
                       mem_a_o !== 32'd0) begin miscompares++;
            $display("FAIL midfetch_reset got req=%b done=%b inst=%h a=%h want all 0",
                     mem_req_o, inst_done_o, inst_o, mem_a_o); end
        rst = 1'b0; rdy = 1'b1;
        tick();
        exp_q.push_back(32'h0000_0513);
        fetch(32'h0, 1'b1, 0, lat, word, rs, ah);
        e = exp_q.pop_front();
        vectors++; if (lat != 6 || word !== e) begin miscompares++;
            $display("FAIL reset_clears_valid got lat=%0d word=%h want 6 %h", lat, word, e); end
        exp_q.push_back(32'h00b5_2023);
        fetch(32'h20, 1'b1, 0, lat, word, rs, ah);
        e = exp_q.pop_front();
        vectors++; if (lat != 6 || word !== e) begin miscompares++;
            $display("FAIL midfetch_refetch got lat=%0d word=%h want 6 %h", lat, word, e); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
        {ram[8'h00], ram[8'h01], ram[8'h02], ram[8'h03]} = {8'h13, 8'h05, 8'h00, 8'h00};
        {ram[8'h08], ram[8'h09], ram[8'h0A], ram[8'h0B]} = {8'hb7, 8'h12, 8'h34, 8'h12};
        {ram[8'h0C], ram[8'h0D], ram[8'h0E], ram[8'h0F]} = {8'h33, 8'h85, 8'ha5, 8'h00};
        {ram[8'h20], ram[8'h21], ram[8'h22], ram[8'h23]} = {8'h23, 8'h20, 8'hb5, 8'h00};
        {ram[8'h40], ram[8'h41], ram[8'h42], ram[8'h43]} = {8'h93, 8'h00, 8'h10, 8'h00};
        {ram[8'h80], ram[8'h81], ram[8'h82], ram[8'h83]} = {8'h13, 8'h01, 8'h01, 8'hff};
        {ram[8'h90], ram[8'h91], ram[8'h92], ram[8'h93]} = {8'h6f, 8'h00, 8'h00, 8'h00};
        {ram[8'hFC], ram[8'hFD], ram[8'hFE], ram[8'hFF]} = {8'h67, 8'h80, 8'h00, 8'h00};

        test_reset();
        test_miss();
        test_hit();
        test_conflict();
        test_gnt_delay();
        test_rdy_stall();
        test_flush();
        test_flush_final();
        test_flush_hit();
        test_wrap();
        test_back_to_back();
        test_reset_midfetch();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
